fft_err_pos_reader: RTL and testbench

Reader side of the decap FFT result RAM. After the additive FFT has written one DW-bit evaluation per RAM address, this block scans addresses 0..N1-1 and reports every address whose evaluation is zero as an error position. Positions leave on a ready/valid stream toward the error-correction stage, together with an error count and a failure flag. The block sits between the FFT result RAM read port and the Reed-Solomon error-value/correction logic.

---
 rtl/fft_err_pos_reader.sv | 198 +++++++++++++++++++
 tb/tb_fft_err_pos_reader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_err_pos_reader.sv
// ---------------------------------------------------------------------------
// fft_err_pos_reader
//
// Reader side of the decap FFT result RAM. Scans RAM addresses 0..N1-1 and
// reports every address whose DW-bit evaluation is zero as an error position.
// Positions leave in ascending order on a ready/valid stream through a
// 2-entry registered FIFO. An error count and a failure flag (count > DELTA)
// accompany the stream and are held until the next start.
//
// Optional feature macro: FFT_ERR_BITMAP_EN
//   defined   -> err_map_o is a registered bitmap of error positions
//   undefined -> err_map_o is tied to zero and no bitmap register is built
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   start_i           one-cycle start pulse, ignored unless idle
//   busy_o, done_o    scan in progress / one-cycle completion pulse
//   ram_rd_o          RAM read strobe
//   ram_addr_o        RAM read address (valid with ram_rd_o)
//   ram_dout_i        RAM read data, valid one cycle after ram_rd_o
//   pos_o             error position at the FIFO head
//   pos_valid_o       pos_o valid
//   pos_ready_i       consumer accepts pos_o
//   err_cnt_o         number of zero evaluations found
//   fail_o            err_cnt_o exceeds DELTA
//   err_map_o         per-position error bitmap
// ---------------------------------------------------------------------------
module fft_err_pos_reader #(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int N1    = 46,
    parameter int DELTA = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          ram_rd_o,
    output logic [AW-1:0] ram_addr_o,
    input  logic [DW-1:0] ram_dout_i,
    output logic [AW-1:0] pos_o,
    output logic          pos_valid_o,
    input  logic          pos_ready_i,
    output logic [AW:0]   err_cnt_o,
    output logic          fail_o,
    output logic [N1-1:0] err_map_o
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW-1:0] ret_addr_q, ret_addr_d;
    logic          inflight_q, inflight_d;
    logic [AW-1:0] fifo_mem_q [2];
    logic [AW-1:0] fifo_mem_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    fifo_cnt_q, fifo_cnt_d;
    logic [AW:0]   err_cnt_q, err_cnt_d;
    logic [AW:0]   cnt_inc;
    logic          fail_q, fail_d;

    logic          pop;
    logic          hit;
    logic          issue;
    logic          drained;
    logic [2:0]    occupancy;

    // Occupancy the FIFO will have once this cycle's pop and the pending
    // return are accounted for. Issuing only while it is below 2 leaves room
    // for the new read's return even if every evaluation is zero.
    always_comb begin
        pop       = (fifo_cnt_q != 2'd0) && pos_ready_i;
        hit       = inflight_q && (ram_dout_i == '0);
        occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = (state_q == SCAN) && (occupancy < 3'd2);
        drained   = (state_q == DRAIN) && !inflight_q && (fifo_cnt_q == 2'd0);
        cnt_inc   = err_cnt_q + (AW+1)'(1);
    end

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        ret_addr_d = ret_addr_q;
        inflight_d = issue;
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        err_cnt_d  = err_cnt_q;
        fail_d     = fail_q;

        case (state_q)
            IDLE:    if (start_i) state_d = SCAN;
            SCAN:    if (issue && (rd_addr_q == AW'(N1 - 1))) state_d = DRAIN;
            DRAIN:   if (drained) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The issued address is kept so the return one cycle later can be
        // tagged with the position it belongs to.
        if (issue) begin
            rd_addr_d  = rd_addr_q + AW'(1);
            ret_addr_d = rd_addr_q;
        end

        if (hit) begin
            fifo_mem_d[wr_ptr_q] = ret_addr_q;
            wr_ptr_d             = ~wr_ptr_q;
            err_cnt_d            = cnt_inc;
            if (cnt_inc > (AW+1)'(DELTA)) fail_d = 1'b1;
        end

        if (pop) rd_ptr_d = ~rd_ptr_q;

        case ({hit, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        // An accepted start wipes the previous scan's results.
        if ((state_q == IDLE) && start_i) begin
            rd_addr_d  = '0;
            err_cnt_d  = '0;
            fail_d     = 1'b0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            fifo_cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            rd_addr_q     <= '0;
            ret_addr_q    <= '0;
            inflight_q    <= 1'b0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_cnt_q    <= 2'd0;
            err_cnt_q     <= '0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            ret_addr_q    <= ret_addr_d;
            inflight_q    <= inflight_d;
            fifo_mem_q[0] <= fifo_mem_d[0];
            fifo_mem_q[1] <= fifo_mem_d[1];
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            err_cnt_q     <= err_cnt_d;
            fail_q        <= fail_d;
        end
    end

`ifdef FFT_ERR_BITMAP_EN
    logic [N1-1:0] err_map_q, err_map_d;

    // The returned address is compared against each bit position so the
    // index never needs to be narrowed to the bitmap width.
    always_comb begin
        err_map_d = err_map_q;
        if ((state_q == IDLE) && start_i) begin
            err_map_d = '0;
        end else begin
            for (int p = 0; p < N1; p++) begin
                if (hit && (ret_addr_q == AW'(p))) err_map_d[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) err_map_q <= '0;
        else       err_map_q <= err_map_d;
    end

    assign err_map_o = err_map_q;
`else
    assign err_map_o = '0;
`endif

    assign busy_o      = (state_q != IDLE);
    assign done_o      = drained;
    assign ram_rd_o    = issue;
    assign ram_addr_o  = rd_addr_q;
    assign pos_o       = fifo_mem_q[rd_ptr_q];
    assign pos_valid_o = (fifo_cnt_q != 2'd0);
    assign err_cnt_o   = err_cnt_q;
    assign fail_o      = fail_q;

endmodule

// File: tb/tb_fft_err_pos_reader.sv
// ---------------------------------------------------------------------------
// tb_fft_err_pos_reader
//
// Directed bench for fft_err_pos_reader: a behavioural RAM with one-cycle
// read latency, a ready pattern generator, and a monitor that collects the
// emitted position stream. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_fft_err_pos_reader;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int N1    = 46;
    localparam int DELTA = 15;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          busy_o;
    logic          done_o;
    logic          ram_rd_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_dout_i;
    logic [AW-1:0] pos_o;
    logic          pos_valid_o;
    logic          pos_ready_i;
    logic [AW:0]   err_cnt_o;
    logic          fail_o;
    logic [N1-1:0] err_map_o;

    logic [DW-1:0] mem [256];

    int assertCount    = 0;
    int failCount      = 0;
    int cycleNo        = 0;
    int readyMode      = 0;
    int doneCount      = 0;
    int doneCycle      = 0;
    int scanStart      = 0;
    int firstFailCycle = -1;
    int heldPos        = 0;
    bit holdPrev       = 1'b0;
    int gotQ[$];
    int popCycleQ[$];

    fft_err_pos_reader #(.AW(AW), .DW(DW), .N1(N1), .DELTA(DELTA)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ram_rd_o    (ram_rd_o),
        .ram_addr_o  (ram_addr_o),
        .ram_dout_i  (ram_dout_i),
        .pos_o       (pos_o),
        .pos_valid_o (pos_valid_o),
        .pos_ready_i (pos_ready_i),
        .err_cnt_o   (err_cnt_o),
        .fail_o      (fail_o),
        .err_map_o   (err_map_o)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk_i = ~clk_i;

    // Cycle counter; cycle k is the interval following the k-th rising edge
    always @(posedge clk_i) cycleNo++;

    // Result RAM model: data appears exactly one cycle after the read strobe
    always @(posedge clk_i) begin
        if (ram_rd_o) ram_dout_i <= mem[ram_addr_o];
    end

    // Consumer ready: always ready in mode 0, ready one cycle in three in mode 1
    always @(posedge clk_i) begin
        #2;
        pos_ready_i = (readyMode == 0) ? 1'b1 : ((cycleNo % 3) == 0);
    end

    // Mid-cycle monitor: records pops and done pulses, checks that a stalled
    // head holds its value, and notes when fail_o first rises during a scan
    always @(negedge clk_i) begin
        if (holdPrev) begin
            checkOutput("posHoldValid", 64'(pos_valid_o), 64'd1);
            checkOutput("posHoldData", 64'(pos_o), 64'(heldPos));
        end
        holdPrev = pos_valid_o && !pos_ready_i && !rst_i;
        heldPos  = int'(pos_o);
        if (pos_valid_o && pos_ready_i && !rst_i) begin
            gotQ.push_back(int'(pos_o));
            popCycleQ.push_back(cycleNo);
        end
        if (done_o) begin
            doneCount++;
            doneCycle = cycleNo;
        end
        if (fail_o && busy_o && firstFailCycle < 0) firstFailCycle = cycleNo;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Bitmap expectation depends on whether the bitmap is built
    function automatic logic [63:0] expectMap(input logic [63:0] m);
`ifdef FFT_ERR_BITMAP_EN
        return m;
`else
        return (m & 64'd0);
`endif
    endfunction

    task automatic fillAll(input logic [DW-1:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    function automatic int gotAt(input int k);
        return (gotQ.size() > k) ? gotQ[k] : -1;
    endfunction

    // Runs one scan: start pulse, optional second start at offset
    // secondStartAt, bounded wait for done, returns done latency
    task automatic applyStimulus(input int secondStartAt, output int doneLat);
        int tStart;
        int waited;
        gotQ.delete();
        popCycleQ.delete();
        doneCount      = 0;
        firstFailCycle = -1;
        @(posedge clk_i); #2;
        start_i   = 1'b1;
        tStart    = cycleNo;
        scanStart = tStart;
        @(posedge clk_i); #2;
        start_i = 1'b0;
        @(negedge clk_i);
        checkOutput("busyAfterStart", 64'(busy_o), 64'd1);
        checkOutput("firstRead", 64'(ram_rd_o), 64'd1);
        checkOutput("firstAddr", 64'(ram_addr_o), 64'd0);
        waited = 0;
        while (doneCount == 0 && waited < 400) begin
            @(posedge clk_i); #2;
            start_i = (secondStartAt > 0) && ((cycleNo - tStart) == secondStartAt);
            @(negedge clk_i);
            waited++;
        end
        start_i = 1'b0;
        if (doneCount == 0) checkOutput("doneTimeout", 64'd0, 64'd1);
        doneLat = doneCycle - tStart;
        repeat (5) @(negedge clk_i);
        checkOutput("singleDone", 64'(doneCount), 64'd1);
    endtask

    initial begin
        int lat;
        rst_i       = 1'b1;
        start_i     = 1'b0;
        pos_ready_i = 1'b1;
        ram_dout_i  = '0;
        fillAll(8'h01);

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("rstBusy", 64'(busy_o), 64'd0);
        checkOutput("rstDone", 64'(done_o), 64'd0);
        checkOutput("rstRamRd", 64'(ram_rd_o), 64'd0);
        checkOutput("rstPosValid", 64'(pos_valid_o), 64'd0);
        checkOutput("rstFail", 64'(fail_o), 64'd0);
        checkOutput("rstAddr", 64'(ram_addr_o), 64'd0);
        checkOutput("rstPos", 64'(pos_o), 64'd0);
        checkOutput("rstErrCnt", 64'(err_cnt_o), 64'd0);
        checkOutput("rstMap", 64'(err_map_o), 64'd0);
        @(posedge clk_i); #2;
        rst_i = 1'b0;

        // No errors
        fillAll(8'h01);
        applyStimulus(0, lat);
        checkOutput("noErrDoneLat", 64'(lat), 64'd48);
        checkOutput("noErrPops", 64'(gotQ.size()), 64'd0);
        checkOutput("noErrCnt", 64'(err_cnt_o), 64'd0);
        checkOutput("noErrFail", 64'(fail_o), 64'd0);
        checkOutput("noErrMap", 64'(err_map_o), 64'd0);

        // Three errors at 3, 17, 45
        fillAll(8'h01);
        mem[3] = 8'h00; mem[17] = 8'h00; mem[45] = 8'h00;
        applyStimulus(0, lat);
        checkOutput("threeDoneLat", 64'(lat), 64'd49);
        checkOutput("threePops", 64'(gotQ.size()), 64'd3);
        checkOutput("threePos0", 64'(gotAt(0)), 64'd3);
        checkOutput("threePos1", 64'(gotAt(1)), 64'd17);
        checkOutput("threePos2", 64'(gotAt(2)), 64'd45);
        checkOutput("hitLatency", 64'((popCycleQ.size() > 0) ? popCycleQ[0] - scanStart : -1), 64'd6);
        checkOutput("threeCnt", 64'(err_cnt_o), 64'd3);
        checkOutput("threeFail", 64'(fail_o), 64'd0);
        checkOutput("threeMap", 64'(err_map_o), expectMap(64'h0000_2000_0002_0008));

        // Backpressure, every position an error
        fillAll(8'h00);
        readyMode = 1;
        applyStimulus(0, lat);
        readyMode = 0;
        checkOutput("bpPops", 64'(gotQ.size()), 64'd46);
        for (int i = 0; i < gotQ.size(); i++) checkOutput("bpOrder", 64'(gotQ[i]), 64'(i));
        checkOutput("bpDoneAfterPop", 64'((popCycleQ.size() > 0) && (doneCycle > popCycleQ[$])), 64'd1);
        checkOutput("bpCnt", 64'(err_cnt_o), 64'd46);
        checkOutput("bpFail", 64'(fail_o), 64'd1);
        checkOutput("bpMap", 64'(err_map_o), expectMap(64'h0000_3FFF_FFFF_FFFF));

        // Failure: 16 errors at even addresses 0..30
        fillAll(8'h01);
        for (int k = 0; k < 16; k++) mem[2*k] = 8'h00;
        applyStimulus(0, lat);
        checkOutput("failDoneLat", 64'(lat), 64'd48);
        checkOutput("failCnt", 64'(err_cnt_o), 64'd16);
        checkOutput("failFlag", 64'(fail_o), 64'd1);
        checkOutput("failRiseCycle", 64'(firstFailCycle - scanStart), 64'd33);
        checkOutput("failMap", 64'(err_map_o), expectMap(64'h0000_0000_5555_5555));
        repeat (4) @(negedge clk_i);
        checkOutput("failHeld", 64'(fail_o), 64'd1);
        checkOutput("failCntHeld", 64'(err_cnt_o), 64'd16);

        // Start while busy: second start at offset 10 is ignored
        fillAll(8'h01);
        mem[3] = 8'h00; mem[17] = 8'h00; mem[45] = 8'h00;
        applyStimulus(10, lat);
        checkOutput("busyStartLat", 64'(lat), 64'd49);
        checkOutput("busyStartPops", 64'(gotQ.size()), 64'd3);
        checkOutput("busyStartCnt", 64'(err_cnt_o), 64'd3);
        checkOutput("busyStartFail", 64'(fail_o), 64'd0);

        // Reset at cycle 20 of a scan
        fillAll(8'h00);
        doneCount = 0;
        @(posedge clk_i); #2;
        start_i = 1'b1;
        @(posedge clk_i); #2;
        start_i = 1'b0;
        repeat (19) @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("midRstBusy", 64'(busy_o), 64'd0);
        checkOutput("midRstRamRd", 64'(ram_rd_o), 64'd0);
        checkOutput("midRstAddr", 64'(ram_addr_o), 64'd0);
        checkOutput("midRstPosValid", 64'(pos_valid_o), 64'd0);
        checkOutput("midRstPos", 64'(pos_o), 64'd0);
        checkOutput("midRstCnt", 64'(err_cnt_o), 64'd0);
        checkOutput("midRstFail", 64'(fail_o), 64'd0);
        checkOutput("midRstMap", 64'(err_map_o), 64'd0);
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        repeat (6) @(negedge clk_i);
        checkOutput("midRstNoDone", 64'(doneCount), 64'd0);

        // Full scan after the aborted one
        fillAll(8'h01);
        mem[3] = 8'h00; mem[17] = 8'h00; mem[45] = 8'h00;
        applyStimulus(0, lat);
        checkOutput("postRstLat", 64'(lat), 64'd49);
        checkOutput("postRstPos0", 64'(gotAt(0)), 64'd3);
        checkOutput("postRstPos1", 64'(gotAt(1)), 64'd17);
        checkOutput("postRstPos2", 64'(gotAt(2)), 64'd45);
        checkOutput("postRstCnt", 64'(err_cnt_o), 64'd3);
        checkOutput("postRstMap", 64'(err_map_o), expectMap(64'h0000_2000_0002_0008));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
